// File: rtl/ram_access_unit_pkg.sv
// Shared types and size helpers for the RAM access unit.
// Sizes follow the load/store funct3 encoding; 2'b11 is handled as a word.
package ram_access_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    function automatic logic [2:0] size_bytes(logic [1:0] size);
        case (size)
            MEM_BYTE: return 3'd1;
            MEM_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(logic [1:0] size);
        case (size)
            MEM_BYTE: return 4'b0001;
            MEM_HALF: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    // True when the access crosses into the next word.
    function automatic logic is_split(logic [1:0] off, logic [1:0] size);
        return ({1'b0, off} + size_bytes(size)) > 3'd4;
    endfunction

endpackage

// File: rtl/ram_access_unit_load_extract.sv
// Selects the addressed bytes of a (possibly two-word) load
// and sign- or zero-extends them to 32 bits.
module load_extract
    import ram_access_unit_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output word_t       result
);

    logic [63:0] shifted;
    logic        fill;

    always_comb begin
        shifted = data >> {off, 3'b000};
        fill    = 1'b0;
        result  = shifted[31:0];
        case (size)
            MEM_BYTE: begin
                fill   = ~is_unsigned & shifted[7];
                result = {{24{fill}}, shifted[7:0]};
            end
            MEM_HALF: begin
                fill   = ~is_unsigned & shifted[15];
                result = {{16{fill}}, shifted[15:0]};
            end
            default: result = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/ram_access_unit.sv
// Load/store front end to system_ram: lane shifting, byte masks,
// two-beat handling of word-crossing accesses and load extension.
module ram_access_unit
    import ram_access_unit_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_data_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_error_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_write_data_o,
    output logic [3:0]  ram_write_mask_o,
    input  logic [31:0] ram_read_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    state_t     state;
    word_t      addr_q;
    word_t      data_q;
    word_t      lo_q;
    logic [1:0] size_q;
    logic       write_q;
    logic       unsigned_q;
    logic       err_q;

    logic        split;
    logic        req_split;
    logic [63:0] wdata64;
    logic [7:0]  mask8;
    logic [63:0] load_word;
    word_t       ext_word;
    word_t       base_addr;

    assign split     = is_split(addr_q[1:0], size_q);
    assign req_split = is_split(req_addr_i[1:0], req_size_i);
    assign wdata64   = {32'h0, data_q} << {addr_q[1:0], 3'b000};
    assign mask8     = {4'h0, size_mask(size_q)} << addr_q[1:0];
    assign base_addr = {addr_q[31:2], 2'b00};

    assign req_ready_o = (state == IDLE) || (state == RESP);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            lo_q       <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (req_valid_i) begin
                        addr_q     <= req_addr_i;
                        data_q     <= req_data_i;
                        size_q     <= req_size_i;
                        write_q    <= req_write_i;
                        unsigned_q <= req_unsigned_i;
                        // Rejected accesses answer next cycle, RAM untouched.
                        if (!ALLOW_MISALIGNED && req_split) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= BEAT0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BEAT0: state <= split ? BEAT1 : RESP;
                BEAT1: begin
                    lo_q  <= ram_read_data_i;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_addr_o       = '0;
        ram_write_data_o = '0;
        ram_write_mask_o = '0;
        case (state)
            BEAT0: begin
                ram_addr_o       = base_addr;
                ram_write_data_o = wdata64[31:0];
                ram_write_mask_o = write_q ? mask8[3:0] : 4'b0000;
            end
            BEAT1: begin
                ram_addr_o       = base_addr + 32'd4;
                ram_write_data_o = wdata64[63:32];
                ram_write_mask_o = write_q ? mask8[7:4] : 4'b0000;
            end
            default: ;
        endcase
    end

    assign load_word = split ? {ram_read_data_i, lo_q}
                             : {32'h0, ram_read_data_i};

    load_extract u_extract (
        .data        (load_word),
        .off         (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .result      (ext_word)
    );

    assign resp_valid_o = (state == RESP);
    assign resp_error_o = (state == RESP) && err_q;
    assign resp_data_o  = (state == RESP && !write_q && !err_q)
                        ? ext_word : '0;

endmodule

// File: tb/tb_ram_access_unit.sv
// Bench: two units (splitting / rejecting) each with a word RAM,
// checked every cycle against a byte-level transaction model.
module tb_ram_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid;
    logic        req_write;
    logic        req_uns;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_data;

    logic [1:0]       req_ready;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_error;
    logic [1:0][31:0] resp_data;
    logic [1:0][31:0] ram_addr;
    logic [1:0][31:0] ram_wd;
    logic [1:0][31:0] ram_rd;
    logic [1:0][3:0]  ram_wm;

    ram_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready[0]),
        .req_addr_i       (req_addr),
        .req_write_i      (req_write),
        .req_size_i       (req_size),
        .req_unsigned_i   (req_uns),
        .req_data_i       (req_data),
        .resp_valid_o     (resp_valid[0]),
        .resp_data_o      (resp_data[0]),
        .resp_error_o     (resp_error[0]),
        .ram_addr_o       (ram_addr[0]),
        .ram_write_data_o (ram_wd[0]),
        .ram_write_mask_o (ram_wm[0]),
        .ram_read_data_i  (ram_rd[0])
    );

    ram_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clk_i            (clk),
        .reset_i          (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready[1]),
        .req_addr_i       (req_addr),
        .req_write_i      (req_write),
        .req_size_i       (req_size),
        .req_unsigned_i   (req_uns),
        .req_data_i       (req_data),
        .resp_valid_o     (resp_valid[1]),
        .resp_data_o      (resp_data[1]),
        .resp_error_o     (resp_error[1]),
        .ram_addr_o       (ram_addr[1]),
        .ram_write_data_o (ram_wd[1]),
        .ram_write_mask_o (ram_wm[1]),
        .ram_read_data_i  (ram_rd[1])
    );

    // system_ram stand-in: byte-masked writes, 1-cycle registered read
    logic [31:0] mem [2][256];
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            for (int b = 0; b < 4; b++)
                if (ram_wm[u][b])
                    mem[u][ram_addr[u][9:2]][8*b +: 8] <= ram_wd[u][8*b +: 8];
            ram_rd[u] <= mem[u][ram_addr[u][9:2]];
        end
    end

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [7:0]  mm [2][1024];
    bit          pend [2];
    bit          e_err [2];
    bit          e_split [2];
    int          rcyc [2];
    int          bcyc [2];
    logic [31:0] e_data [2];
    logic [31:0] e_b0a [2];
    logic [31:0] e_b0d [2];
    logic [31:0] e_b1a [2];
    logic [31:0] e_b1d [2];
    logic [3:0]  e_b0m [2];
    logic [3:0]  e_b1m [2];

    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 256; i++) mem[u][i] = '0;
            for (int i = 0; i < 1024; i++) mm[u][i] = '0;
            pend[u] = 0;
        end
    end

    task automatic model_accept(input int u);
        int          nb;
        int          off;
        logic [63:0] w64;
        logic [7:0]  m8;
        logic [31:0] v;
        logic [31:0] ba;
        nb  = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        off = int'(req_addr[1:0]);
        pend[u]    = 1;
        e_split[u] = (off + nb) > 4;
        e_err[u]   = (u == 1) && e_split[u];
        rcyc[u]    = cyc + (e_err[u] ? 1 : e_split[u] ? 3 : 2);
        bcyc[u]    = cyc + 1;
        w64 = {32'h0, req_data} << (8 * off);
        m8  = 8'((1 << nb) - 1) << off;
        e_b0a[u] = {req_addr[31:2], 2'b00};
        e_b1a[u] = e_b0a[u] + 32'd4;
        e_b0d[u] = w64[31:0];
        e_b1d[u] = w64[63:32];
        e_b0m[u] = req_write ? m8[3:0] : 4'h0;
        e_b1m[u] = req_write ? m8[7:4] : 4'h0;
        e_data[u] = '0;
        if (!e_err[u]) begin
            if (req_write) begin
                for (int k = 0; k < nb; k++) begin
                    ba = req_addr + 32'(k);
                    mm[u][ba[9:0]] = req_data[8*k +: 8];
                end
            end else begin
                v = '0;
                for (int k = 0; k < nb; k++) begin
                    ba = req_addr + 32'(k);
                    v  = v | ({24'h0, mm[u][ba[9:0]]} << (8 * k));
                end
                if (!req_uns && nb < 4 && v[8*nb-1])
                    v = v | ~((32'h1 << (8 * nb)) - 32'h1);
                e_data[u] = v;
            end
        end
    endtask

    logic        ex_rdy;
    logic        ex_rv;
    logic        ex_err;
    logic [31:0] ex_rd;
    logic [31:0] ex_a;
    logic [31:0] ex_d;
    logic [3:0]  ex_m;

    always @(negedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            ex_rdy = 1'b1;
            ex_rv  = 1'b0;
            ex_err = 1'b0;
            ex_rd  = '0;
            ex_a   = '0;
            ex_d   = '0;
            ex_m   = '0;
            if (rst) begin
                pend[u] = 0;
            end else if (pend[u]) begin
                ex_rdy = (cyc == rcyc[u]);
                ex_rv  = (cyc == rcyc[u]);
                ex_err = ex_rv && e_err[u];
                ex_rd  = ex_rv ? e_data[u] : 32'h0;
                if (!e_err[u] && cyc == bcyc[u]) begin
                    ex_a = e_b0a[u];
                    ex_d = e_b0d[u];
                    ex_m = e_b0m[u];
                end
                if (!e_err[u] && e_split[u] && cyc == bcyc[u] + 1) begin
                    ex_a = e_b1a[u];
                    ex_d = e_b1d[u];
                    ex_m = e_b1m[u];
                end
            end
            checks++;
            if (req_ready[u] !== ex_rdy || resp_valid[u] !== ex_rv ||
                resp_error[u] !== ex_err || resp_data[u] !== ex_rd ||
                ram_addr[u] !== ex_a || ram_wd[u] !== ex_d ||
                ram_wm[u] !== ex_m) begin
                fails++;
                $display("FAIL cycle u%0d cyc=%0d got rdy=%b rv=%b err=%b rd=%h a=%h d=%h m=%b expected rdy=%b rv=%b err=%b rd=%h a=%h d=%h m=%b",
                         u, cyc, req_ready[u], resp_valid[u], resp_error[u],
                         resp_data[u], ram_addr[u], ram_wd[u], ram_wm[u],
                         ex_rdy, ex_rv, ex_err, ex_rd, ex_a, ex_d, ex_m);
            end
            if (!rst) begin
                if (ex_rv) pend[u] = 0;
                if (req_valid && ex_rdy) model_accept(u);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] t_rd;
    logic [31:0] t_b0a;
    logic [31:0] t_b0d;
    logic [31:0] t_b1a;
    logic [31:0] t_b1d;
    logic [3:0]  t_b0m;
    logic [3:0]  t_b1m;
    logic        t_err;
    int          t_lat;

    task automatic issue(input int u, input bit w, input logic [1:0] sz,
                         input bit uns, input logic [31:0] a,
                         input logic [31:0] d);
        bit acc;
        acc = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_uns   = uns;
        req_addr  = a;
        req_data  = d;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready[u];
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout u%0d addr=%h", u, a);
        end
    endtask

    task automatic do_req(input int u, input bit w, input logic [1:0] sz,
                          input bit uns, input logic [31:0] a,
                          input logic [31:0] d);
        bit got;
        got   = 0;
        t_lat = 0;
        t_rd  = 'x;
        t_err = 1'bx;
        issue(u, w, sz, uns, a, d);
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                t_b0a = ram_addr[u];
                t_b0d = ram_wd[u];
                t_b0m = ram_wm[u];
            end
            if (i == 2) begin
                t_b1a = ram_addr[u];
                t_b1d = ram_wd[u];
                t_b1m = ram_wm[u];
            end
            if (resp_valid[u]) begin
                got   = 1;
                t_lat = i;
                t_rd  = resp_data[u];
                t_err = resp_error[u];
            end
        end
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL resp_timeout u%0d addr=%h", u, a);
        end
    endtask

    int          n_acc;
    int          n_rsp;
    int          acc_c [3];
    logic [31:0] rsp [3];

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'd0;
        req_uns   = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready[0]}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid[0]}, 32'h0);
        chk("rst_resp_data", resp_data[0], 32'h0);
        chk("rst_ram_addr", ram_addr[0], 32'h0);
        chk("rst_ram_mask", {28'h0, ram_wm[0]}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        do_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        chk("sw_lat", t_lat, 2);
        chk("sw_b0_mask", {28'h0, t_b0m}, 32'hF);
        chk("sw_b0_addr", t_b0a, 32'h10);
        do_req(0, 0, 2'd2, 0, 32'h10, 32'h0);
        chk("lw_lat", t_lat, 2);
        chk("lw_data", t_rd, 32'hDEADBEEF);

        do_req(0, 1, 2'd2, 0, 32'h10, 32'h11223344);
        do_req(0, 1, 2'd0, 0, 32'h13, 32'h000000A5);
        do_req(0, 0, 2'd0, 0, 32'h13, 32'h0);
        chk("lb_data", t_rd, 32'hFFFFFFA5);
        do_req(0, 0, 2'd0, 1, 32'h13, 32'h0);
        chk("lbu_data", t_rd, 32'h000000A5);
        do_req(0, 0, 2'd2, 0, 32'h10, 32'h0);
        chk("lw_merge", t_rd, 32'hA5223344);

        do_req(0, 1, 2'd2, 0, 32'h22, 32'hCAFEF00D);
        chk("split_lat", t_lat, 3);
        chk("split_b0_addr", t_b0a, 32'h20);
        chk("split_b0_mask", {28'h0, t_b0m}, 32'hC);
        chk("split_b0_data", t_b0d, 32'hF00D0000);
        chk("split_b1_addr", t_b1a, 32'h24);
        chk("split_b1_mask", {28'h0, t_b1m}, 32'h3);
        chk("split_b1_data", t_b1d, 32'h0000CAFE);
        do_req(0, 0, 2'd2, 0, 32'h22, 32'h0);
        chk("split_lw_lat", t_lat, 3);
        chk("split_lw_data", t_rd, 32'hCAFEF00D);

        do_req(1, 0, 2'd1, 0, 32'h0F, 32'h0);
        chk("rej_lat", t_lat, 1);
        chk("rej_err", {31'h0, t_err}, 32'h1);
        chk("rej_data", t_rd, 32'h0);
        chk("rej_mask", {28'h0, t_b0m}, 32'h0);
        chk("rej_addr", t_b0a, 32'h0);

        do_req(0, 1, 2'd2, 0, 32'h0, 32'h0A0A0A0A);
        do_req(0, 1, 2'd2, 0, 32'h4, 32'h1B1B1B1B);
        do_req(0, 1, 2'd2, 0, 32'h8, 32'h2C2C2C2C);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0;
        n_acc = 0;
        n_rsp = 0;
        for (int c = 0; c < 20 && n_rsp < 3; c++) begin
            @(negedge clk);
            if (resp_valid[0]) begin
                rsp[n_rsp] = resp_data[0];
                n_rsp++;
            end
            if (req_valid && req_ready[0] && n_acc < 3) begin
                acc_c[n_acc] = c;
                n_acc++;
            end
            @(posedge clk);
            #1;
            req_valid = (n_acc < 3);
            req_addr  = 32'(4 * n_acc);
        end
        req_valid = 1'b0;
        chk("b2b_accepts", n_acc, 3);
        chk("b2b_resps", n_rsp, 3);
        if (n_acc == 3) begin
            chk("b2b_gap1", acc_c[1] - acc_c[0], 2);
            chk("b2b_gap2", acc_c[2] - acc_c[1], 2);
        end
        if (n_rsp == 3) begin
            chk("b2b_rsp0", rsp[0], 32'h0A0A0A0A);
            chk("b2b_rsp1", rsp[1], 32'h1B1B1B1B);
            chk("b2b_rsp2", rsp[2], 32'h2C2C2C2C);
        end

        issue(0, 0, 2'd2, 0, 32'h22, 32'h0);
        @(posedge clk);
        #3;
        chk("beat1_addr", ram_addr[0], 32'h24);
        rst = 1'b1;
        #1;
        chk("mid_rst_addr", ram_addr[0], 32'h0);
        chk("mid_rst_mask", {28'h0, ram_wm[0]}, 32'h0);
        chk("mid_rst_resp", {31'h0, resp_valid[0]}, 32'h0);
        chk("mid_rst_ready", {31'h0, req_ready[0]}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_resp", {31'h0, resp_valid[0]}, 32'h0);
            chk("post_rst_ready", {31'h0, req_ready[0]}, 32'h1);
        end

        repeat (3000) begin
            @(posedge clk);
            #1;
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_size  = 2'($urandom_range(0, 3));
            req_uns   = 1'($urandom_range(0, 1));
            req_data  = $urandom;
            if ($urandom_range(0, 7) == 0)
                req_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                req_addr = 32'($urandom_range(0, 127));
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
